// File: rtl/mem_access_unit.sv
// Load/store initiator for a combinational-read / clocked-write data memory.
// Handles word and byte loads/stores; byte stores are read-modify-write.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [7:0]  req_addr,
    input  logic        req_byte,
    input  logic        req_signed,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [7:0]  mem_address,
    output logic [15:0] mem_datain,
    output logic        mem_load,
    output logic        mem_store,
    input  logic [15:0] mem_dataout
);

    localparam logic [1:0] OP_LW = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_LB = 2'b10;
    localparam logic [1:0] OP_SB = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic        byte_q, byte_d;
    logic        signed_q, signed_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] datain_q, datain_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept_c;
    logic        addr_ok_c;
    logic [7:0]  sel_byte_c;
    logic [15:0] lb_data_c;
    logic [15:0] merged_c;

    assign accept_c   = req_valid && (state_q == IDLE);
    assign addr_ok_c  = (32'(req_addr) < MEM_WORDS);
    assign sel_byte_c = byte_q ? mem_dataout[15:8] : mem_dataout[7:0];
    assign lb_data_c  = signed_q ? {{8{sel_byte_c[7]}}, sel_byte_c} : {8'h00, sel_byte_c};
    assign merged_c   = byte_q ? {wdata_q[7:0], mem_dataout[7:0]}
                               : {mem_dataout[15:8], wdata_q[7:0]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (!addr_ok_c) begin
                        state_d = RESP;
                    end else if (req_op == OP_SW) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = (op_q == OP_SB) ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs; strobes are suppressed while reset is asserted
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_load   = 1'b0;
        mem_store  = 1'b0;
        case (state_q)
            IDLE:    req_ready  = 1'b1;
            READ:    mem_load   = !rst;
            WRITE:   mem_store  = !rst;
            RESP:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch, memory port registers and response registers
    always_comb begin
        op_d     = op_q;
        byte_d   = byte_q;
        signed_d = signed_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        datain_d = datain_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    op_d     = req_op;
                    byte_d   = req_byte;
                    signed_d = req_signed;
                    wdata_d  = req_wdata;
                    if (!addr_ok_c) begin
                        err_d   = 1'b1;
                        rdata_d = 16'h0000;
                    end else begin
                        addr_d = req_addr;
                        if (req_op == OP_SW) begin
                            datain_d = req_wdata;
                        end
                    end
                end
            end
            READ: begin
                err_d = 1'b0;
                case (op_q)
                    OP_LW:   rdata_d = mem_dataout;
                    OP_LB:   rdata_d = lb_data_c;
                    default: rdata_d = 16'h0000;
                endcase
                if (op_q == OP_SB) begin
                    datain_d = merged_c;
                end
            end
            WRITE: begin
                err_d   = 1'b0;
                rdata_d = 16'h0000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_LW;
            byte_q   <= 1'b0;
            signed_q <= 1'b0;
            wdata_q  <= 16'h0000;
            addr_q   <= 8'h00;
            datain_q <= 16'h0000;
            rdata_q  <= 16'h0000;
            err_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            byte_q   <= byte_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            datain_q <= datain_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign mem_address = addr_q;
    assign mem_datain  = datain_q;
    assign resp_rdata  = rdata_q;
    assign resp_err    = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: stimulus pushes expected responses
// computed from a word-array reference model; a monitor pops and compares.
module tb_mem_access_unit;

    localparam int unsigned MEM_WORDS = 10;
    localparam logic [1:0] LW = 2'b00;
    localparam logic [1:0] SW = 2'b01;
    localparam logic [1:0] LB = 2'b10;
    localparam logic [1:0] SB = 2'b11;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_addr;
    logic        req_byte;
    logic        req_signed;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_address;
    logic [15:0] mem_datain;
    logic        mem_load;
    logic        mem_store;
    logic [15:0] mem_dataout;

    mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_byte   (req_byte),
        .req_signed (req_signed),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_address(mem_address),
        .mem_datain (mem_datain),
        .mem_load   (mem_load),
        .mem_store  (mem_store),
        .mem_dataout(mem_dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Data memory: combinational read, clocked write
    logic [15:0] mem [0:255];
    bit          preload;
    assign mem_dataout = mem[mem_address];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0111;
        end else if (mem_store) begin
            mem[mem_address] <= mem_datain;
        end
    end

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          lat;
        int          loads;
        int          stores;
        logic [7:0]  waddr;
        logic [15:0] wdata;
    } exp_t;

    exp_t        expq [$];
    logic [15:0] ref_mem [0:MEM_WORDS-1];
    int          n_cmp;
    int          n_fail;
    bit          rr_random;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Monitor: tracks the in-flight request and scores it at the response handshake
    bit          mon_active;
    int          mon_cyc, mon_lat, mon_loads, mon_stores;
    logic [7:0]  mon_waddr;
    logic [15:0] mon_wdata;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_strobes", {30'd0, mem_load, mem_store}, 32'd0);
            mon_active = 1'b0;
        end else begin
            check("strobe_rules",
                  {30'd0, mem_load & mem_store,
                   (req_ready | resp_valid) & (mem_load | mem_store)}, 32'd0);
            if (mon_active) begin
                mon_cyc++;
                if (mem_load) mon_loads++;
                if (mem_store) begin
                    mon_stores++;
                    mon_waddr = mem_address;
                    mon_wdata = mem_datain;
                end
                if (resp_valid && mon_lat < 0) mon_lat = mon_cyc;
                if (resp_valid && resp_ready) begin
                    mon_active = 1'b0;
                    if (expq.size() == 0) begin
                        fail("unexpected_response");
                    end else begin
                        exp_t e;
                        e = expq.pop_front();
                        check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
                        check("resp_err", 32'(resp_err), 32'(e.err));
                        check("latency", 32'(mon_lat), 32'(e.lat));
                        check("load_pulses", 32'(mon_loads), 32'(e.loads));
                        check("store_pulses", 32'(mon_stores), 32'(e.stores));
                        if (e.stores > 0 && mon_stores > 0) begin
                            check("write_addr", 32'(mon_waddr), 32'(e.waddr));
                            check("write_data", 32'(mon_wdata), 32'(e.wdata));
                        end
                    end
                end else if (mon_cyc > 300) begin
                    fail("response_timeout");
                    mon_active = 1'b0;
                end
            end else if (req_valid && req_ready) begin
                mon_active = 1'b1;
                mon_cyc    = 0;
                mon_lat    = -1;
                mon_loads  = 0;
                mon_stores = 0;
            end
        end
    end

    // Random response back-pressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_random) resp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference model: compute expected outcome and update the model memory
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic b,
                         input logic s, input logic [15:0] wd, input bit track);
        exp_t        e;
        logic [15:0] w;
        logic [15:0] v;
        int          t;
        bit          acc;
        if (track) begin
            e.rdata = 16'h0000; e.err = 1'b0; e.lat = 2; e.loads = 0; e.stores = 0;
            e.waddr = addr;     e.wdata = 16'h0000;
            if (32'(addr) >= MEM_WORDS) begin
                e.err = 1'b1;
                e.lat = 1;
            end else begin
                w = ref_mem[int'(addr)];
                case (op)
                    LW: begin e.rdata = w; e.loads = 1; end
                    SW: begin
                        e.stores = 1; e.wdata = wd;
                        ref_mem[int'(addr)] = wd;
                    end
                    LB: begin
                        v = b ? (w >> 8) : (w & 16'h00FF);
                        if (s && v >= 16'h0080) v = v + 16'hFF00;
                        e.rdata = v; e.loads = 1;
                    end
                    default: begin
                        v = b ? ((w & 16'h00FF) + (16'(wd[7:0]) * 16'd256))
                              : ((w & 16'hFF00) + 16'(wd[7:0]));
                        e.lat = 3; e.loads = 1; e.stores = 1; e.wdata = v;
                        ref_mem[int'(addr)] = v;
                    end
                endcase
            end
            expq.push_back(e);
        end
        req_valid = 1'b1; req_op = op; req_addr = addr;
        req_byte = b; req_signed = s; req_wdata = wd;
        acc = 1'b0;
        t = 0;
        while (!acc && t < 300) begin
            @(negedge clk);
            acc = req_ready && !rst;
            @(posedge clk);
            #1;
            t++;
        end
        req_valid = 1'b0;
        if (!acc) fail("accept_timeout");
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((expq.size() != 0 || mon_active) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 3000) fail("drain_timeout");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  32'(req_ready),   32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid),  32'd0);
        check({tag, "_resp_err"},   32'(resp_err),    32'd0);
        check({tag, "_resp_rdata"}, 32'(resp_rdata),  32'd0);
        check({tag, "_mem_load"},   32'(mem_load),    32'd0);
        check({tag, "_mem_store"},  32'(mem_store),   32'd0);
        check({tag, "_mem_addr"},   32'(mem_address), 32'd0);
        check({tag, "_mem_datain"}, 32'(mem_datain),  32'd0);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rr_random = 1'b0; preload = 1'b1;
        rst = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = 8'h00;
        req_byte = 1'b0; req_signed = 1'b0; req_wdata = 16'h0000; resp_ready = 1'b1;
        for (int i = 0; i < int'(MEM_WORDS); i++) ref_mem[i] = 16'h0111;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        // Directed sequence
        issue(LW, 8'd3, 1'b0, 1'b0, 16'h0000, 1'b1);
        issue(SB, 8'd2, 1'b1, 1'b0, 16'h00AB, 1'b1);
        issue(LB, 8'd2, 1'b1, 1'b1, 16'h0000, 1'b1);
        issue(LB, 8'd2, 1'b1, 1'b0, 16'h0000, 1'b1);
        issue(SW, 8'd9, 1'b0, 1'b0, 16'h1234, 1'b1);
        issue(LW, 8'd9, 1'b0, 1'b0, 16'h0000, 1'b1);
        issue(SB, 8'd10, 1'b0, 1'b0, 16'h00CD, 1'b1);
        issue(LW, 8'd255, 1'b0, 1'b0, 16'h0000, 1'b1);
        drain();

        // Response back-pressure with a competing request held during RESP
        rr_random = 1'b0;
        resp_ready = 1'b0;
        issue(LW, 8'd5, 1'b0, 1'b0, 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_op = LW; req_addr = 8'd7;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_resp_valid", 32'(resp_valid), 32'd1);
            check("stall_resp_rdata", 32'(resp_rdata), 32'(ref_mem[5]));
            check("stall_req_ready",  32'(req_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        check("exit_edge_valid", 32'(resp_valid), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_exit_valid", 32'(resp_valid), 32'd0);
        check("after_exit_ready", 32'(req_ready),  32'd1);
        @(posedge clk);
        #1;
        issue(LW, 8'd7, 1'b0, 1'b0, 16'h0000, 1'b1);
        drain();

        // Reset asserted during the WRITE cycle of a byte store
        issue(SB, 8'd4, 1'b0, 1'b0, 16'h0055, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_write_store", 32'(mem_store), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        check("rst_word4", 32'(mem[4]), 32'(ref_mem[4]));
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure
        rr_random = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(10, 255))
                                            : 8'($urandom_range(0, MEM_WORDS - 1));
            issue(2'($urandom_range(0, 3)), a, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            check("final_mem", 32'(mem[i]), 32'(ref_mem[i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that drives the processor's data memory port on behalf of the core datapath. It accepts one request at a time over a valid/ready handshake and sequences the memory's combinational-read / clocked-write port. It supports word and byte loads and stores, with byte stores done as read-modify-write. Out-of-range addresses are rejected without touching memory, and each result is returned over a valid/ready response channel.

## Interface
Parameters:
- MEM_WORDS, 10, number of implemented 16-bit words; legal word addresses 0..MEM_WORDS-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_op  in  2  00 LW, 01 SW, 10 LB, 11 SB.
- req_addr  in  8  word address, unsigned.
- req_byte  in  1  byte lane for LB/SB: 0 = bits 7:0, 1 = bits 15:8.
- req_signed  in  1  LB only: 1 sign-extends, 0 zero-extends.
- req_wdata  in  16  store data; SB uses bits 7:0 only.
- resp_valid  out  1  response available; high only in RESP.
- resp_ready  in  1  core accepts response.
- resp_rdata  out  16  load result; 0 for stores and errors.
- resp_err  out  1  request address >= MEM_WORDS.
- mem_address  out  8  memory word address.
- mem_datain  out  16  memory write data.
- mem_load  out  1  read strobe.
- mem_store  out  1  write strobe; memory writes on the rising edge where it is high.
- mem_dataout  in  16  combinational read data from memory.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - A request is accepted when req_valid and req_ready are both high on a clock edge. That edge latches op, addr, byte, signed and wdata.
  - If addr >= MEM_WORDS: go to RESP with err=1 and rdata=0. No memory strobe is ever issued for this request.
  - Else if op is SW: go to WRITE.
  - Else (LW, LB, SB): go to READ.
- READ:
  - mem_load=1 and mem_address=latched addr; mem_dataout is sampled at the end of the cycle.
  - LW: rdata = word; go to RESP.
  - LB: rdata = the selected byte, extended per the latched signed bit; go to RESP.
  - SB: build the merged word by replacing the selected lane with wdata[7:0] and keeping the other lane; go to WRITE.
- WRITE:
  - mem_store=1 and mem_address=latched addr.
  - mem_datain = wdata for SW, or the merged word for SB.
  - rdata=0; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are stable and registered.
  - Go to IDLE on the edge where resp_ready=1; otherwise hold indefinitely.
- mem_load and mem_store are never both high. Both are 0 in IDLE and RESP.
- mem_address and mem_datain hold their last values when no strobe is active.
- Reset:
  - The rst edge forces IDLE from any state and clears resp_rdata, resp_err, mem_address and mem_datain to 0.
  - mem_store and mem_load are gated by !rst, so a WRITE cycle with rst high performs no write.
  - A request presented while rst is high is not accepted.

## Timing
- Edge 0 is the accept edge; cycle n is the cycle following edge n-1.
- Latency from the accept edge to the first cycle with resp_valid high:
  - error: 1 cycle.
  - SW: 2 cycles (WRITE in cycle 1).
  - LW, LB: 2 cycles (READ in cycle 1).
  - SB: 3 cycles (READ in cycle 1, WRITE in cycle 2).
- Throughput: with resp_ready held high, the next request can be accepted on the edge after RESP exits, so there is one IDLE cycle between requests. There is no request pipelining.
- Outputs after reset:
  - req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_load=0, mem_store=0, mem_address=0, mem_datain=0.
- req_ready depends only on state, not combinationally on req_valid. resp_valid does not depend on resp_ready.
- Boundary addresses:
  - MEM_WORDS-1 is legal.
  - MEM_WORDS and 255 both give err.
  - Addresses are unsigned; there is no wrap-around or sign extension.

## Test plan
- After reset, with all words preloaded to 0x0111:
  - LW addr 3 gives resp_rdata=0x0111, err=0, resp_valid in the second cycle after accept.
  - mem_load is high for exactly one cycle; mem_store stays 0.
- SB addr 2, byte=1, wdata=0x00AB:
  - Exactly one READ cycle, then one WRITE cycle with mem_datain=0xAB11.
  - A following LB addr 2, byte=1, signed=1 returns 0xFFAB; with signed=0 it returns 0x00AB.
- SW addr 9, wdata=0x1234, then LW addr 9: the load returns 0x1234.
  - With MEM_WORDS=10, SB addr 10 and LW addr 255 each give err=1 and rdata=0, one cycle after accept, with no mem_load or mem_store pulse.
- Hold resp_ready low for 3 cycles after LW:
  - resp_valid and resp_rdata are held for those 3 cycles and req_ready stays 0.
  - Exit to IDLE happens on the resp_ready edge.
  - A req_valid presented in RESP is not accepted until IDLE.
- Assert rst during the WRITE cycle of SB addr 4, byte=0, wdata=0x0055:
  - mem_store stays 0 and word 4 remains 0x0111.
  - All outputs take their reset values, and req_ready=1 on the cycle after rst is released.
